// File: rtl/dds_pkg.sv
// Shared widths, enums and mode decode for the DDS sweep controller.
package dds_pkg;

  localparam int unsigned KW  = 32;
  localparam int unsigned PW  = 11;
  localparam int unsigned DWW = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } ctrl_state_e;

  // Reserved encoding 3 falls back to a single sweep.
  function automatic sweep_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_SAW;
      2'd2:    return MODE_TRI;
      default: return MODE_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell counter: counts while enabled, flags the cycle where the count hits
// the limit and rolls back to zero on that cycle.
module dds_dwell_timer #(
  parameter int unsigned DWW = dds_pkg::DWW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [DWW-1:0] limit,
  output logic           expire_c
);

  logic [DWW-1:0] count_q;

  assign expire_c = en && (count_q == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= expire_c ? '0 : count_q + DWW'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding K/P to the DDS core: single, sawtooth and
// triangle sweeps with per-step dwell and saturating step arithmetic.
module dds_sweep_ctrl #(
  parameter int unsigned KW  = dds_pkg::KW,
  parameter int unsigned PW  = dds_pkg::PW,
  parameter int unsigned DWW = dds_pkg::DWW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [KW-1:0]  k_start,
  input  logic [KW-1:0]  k_stop,
  input  logic [KW-1:0]  k_step,
  input  logic [DWW-1:0] dwell,
  input  logic [PW-1:0]  p_offset,
  output logic [KW-1:0]  K,
  output logic [PW-1:0]  P,
  output logic           busy,
  output logic           done,
  output logic           step_tick
);

  import dds_pkg::*;

  ctrl_state_e    state_q, state_d;
  sweep_mode_e    mode_q, mode_d;
  logic [KW-1:0]  k_start_q, k_start_d;
  logic [KW-1:0]  k_stop_q, k_stop_d;
  logic [KW-1:0]  k_step_q, k_step_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [KW-1:0]  k_q, k_d;
  logic [PW-1:0]  p_q, p_d;
  logic           bad_q, bad_d;
  logic           dir_dn_q, dir_dn_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tick_q, tick_d;

  logic           tmr_clr_c;
  logic           tmr_en_c;
  logic           expire_c;

  logic [KW:0]    sum_c;
  logic [KW:0]    diff_c;
  logic [KW-1:0]  k_up_c;
  logic [KW-1:0]  k_dn_c;

  dds_dwell_timer #(.DWW(DWW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .limit    (dwell_q),
    .expire_c (expire_c)
  );

  // Steps are computed one bit wider so carry/borrow saturate instead of wrapping.
  assign sum_c  = {1'b0, k_q} + {1'b0, k_step_q};
  assign diff_c = {1'b0, k_q} - {1'b0, k_step_q};
  assign k_up_c = (sum_c[KW] || (sum_c[KW-1:0] > k_stop_q)) ? k_stop_q : sum_c[KW-1:0];
  assign k_dn_c = (diff_c[KW] || (diff_c[KW-1:0] < k_start_q)) ? k_start_q : diff_c[KW-1:0];

  assign K         = k_q;
  assign P         = p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_tick = tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SINGLE;
      k_start_q <= '0;
      k_stop_q  <= '0;
      k_step_q  <= '0;
      dwell_q   <= '0;
      k_q       <= '0;
      p_q       <= '0;
      bad_q     <= 1'b0;
      dir_dn_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      k_start_q <= k_start_d;
      k_stop_q  <= k_stop_d;
      k_step_q  <= k_step_d;
      dwell_q   <= dwell_d;
      k_q       <= k_d;
      p_q       <= p_d;
      bad_q     <= bad_d;
      dir_dn_q  <= dir_dn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    k_start_d = k_start_q;
    k_stop_d  = k_stop_q;
    k_step_d  = k_step_q;
    dwell_d   = dwell_q;
    k_d       = k_q;
    p_d       = p_q;
    bad_d     = bad_q;
    dir_dn_d  = dir_dn_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tick_d    = 1'b0;
    tmr_clr_c = 1'b1;
    tmr_en_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_d    = decode_mode(mode);
          k_start_d = k_start;
          k_stop_d  = k_stop;
          k_step_d  = k_step;
          dwell_d   = dwell;
          bad_d     = (k_step == '0) || (k_stop < k_start);
          k_d       = k_start;
          p_d       = p_offset;
          dir_dn_d  = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b1;
        if (abort) begin
          tmr_clr_c = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (bad_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else if (expire_c) begin
          if (!dir_dn_q) begin
            if (k_q == k_stop_q) begin
              case (mode_q)
                MODE_SAW: begin
                  k_d    = k_start_q;
                  tick_d = 1'b1;
                end
                MODE_TRI: begin
                  // A zero-width triangle just holds K forever.
                  if (k_start_q != k_stop_q) begin
                    dir_dn_d = 1'b1;
                    k_d      = k_dn_c;
                    tick_d   = 1'b1;
                  end
                end
                default: begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = FIN;
                end
              endcase
            end else begin
              k_d    = k_up_c;
              tick_d = 1'b1;
            end
          end else begin
            if (k_q == k_start_q) begin
              dir_dn_d = 1'b0;
              k_d      = k_up_c;
            end else begin
              k_d = k_dn_c;
            end
            tick_d = 1'b1;
          end
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed plan cases plus randomized
// sweeps compared cycle by cycle against a value-sequence reference model.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] k_start;
  logic [31:0] k_stop;
  logic [31:0] k_step;
  logic [15:0] dwell;
  logic [10:0] p_offset;
  logic [31:0] K;
  logic [10:0] P;
  logic        busy;
  logic        done;
  logic        step_tick;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] k;
    logic        busy;
    logic        done;
    logic        tick;
  } exp_t;

  exp_t trace[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .k_start   (k_start),
    .k_stop    (k_stop),
    .k_step    (k_step),
    .dwell     (dwell),
    .p_offset  (p_offset),
    .K         (K),
    .P         (P),
    .busy      (busy),
    .done      (done),
    .step_tick (step_tick)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input exp_t e, input logic [10:0] po);
    check_val({tag, ".K"}, 64'(K), 64'(e.k));
    check_val({tag, ".P"}, 64'(P), 64'(po));
    check_val({tag, ".busy"}, 64'(busy), 64'(e.busy));
    check_val({tag, ".done"}, 64'(done), 64'(e.done));
    check_val({tag, ".tick"}, 64'(step_tick), 64'(e.tick));
  endtask

  task automatic scramble_inputs();
    mode     = 2'($urandom);
    k_start  = $urandom;
    k_stop   = $urandom;
    k_step   = $urandom;
    dwell    = 16'($urandom);
    p_offset = 11'($urandom);
  endtask

  // Reference: list the K values the sweep visits, each held dwell+1 cycles.
  task automatic build_trace(input logic [1:0] m_raw, input logic [31:0] ks, input logic [31:0] ke,
                             input logic [31:0] st, input logic [15:0] dw, input int max_cyc);
    longint unsigned v, lo, hi, s;
    int  m;
    bit  down, first;
    trace.delete();
    lo = 64'(ks);
    hi = 64'(ke);
    s  = 64'(st);
    m  = (m_raw == 2'd3) ? 0 : int'(m_raw);
    if (s == 0 || hi < lo) begin
      trace.push_back('{k: ks, busy: 1'b1, done: 1'b0, tick: 1'b0});
      trace.push_back('{k: ks, busy: 1'b0, done: 1'b1, tick: 1'b0});
      return;
    end
    v     = lo;
    down  = 1'b0;
    first = 1'b1;
    forever begin
      for (int c = 0; c <= int'(dw); c++)
        trace.push_back('{k: 32'(v), busy: 1'b1, done: 1'b0, tick: (c == 0 && !first)});
      first = (m == 2 && lo == hi);
      if (m == 0 && v == hi) begin
        trace.push_back('{k: 32'(v), busy: 1'b0, done: 1'b1, tick: 1'b0});
        return;
      end
      if (trace.size() >= max_cyc) return;
      if (m == 1 && v == hi) begin
        v = lo;
      end else if (!(m == 2 && lo == hi)) begin
        if (m == 2 && v == hi) down = 1'b1;
        else if (m == 2 && v == lo) down = 1'b0;
        if (down) v = (v < lo + s) ? lo : v - s;
        else      v = (v + s > hi) ? hi : v + s;
      end
    end
  endtask

  task automatic run_sweep(input string nm, input logic [1:0] m, input logic [31:0] ks,
                           input logic [31:0] ke, input logic [31:0] st, input logic [15:0] dw,
                           input logic [10:0] po, input int abort_at);
    logic [31:0] k_last;
    bit          aborted;
    build_trace(m, ks, ke, st, dw, (abort_at > 0) ? abort_at : 4000);
    mode = m; k_start = ks; k_stop = ke; k_step = st; dwell = dw; p_offset = po;
    start = 1'b1;
    abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    k_last  = ks;
    aborted = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      check_cycle($sformatf("%s[%0d]", nm, i), trace[i], po);
      k_last = trace[i].k;
      if (abort_at > 0 && i == abort_at - 1) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_cycle({nm, aborted ? ".abort" : ".idle"},
                '{k: k_last, busy: 1'b0, done: 1'b0, tick: 1'b0}, po);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]      rm;
    logic [31:0]     rks, rke, rst;
    logic [15:0]     rdw;
    longint unsigned ke64;
    int              ab;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode = '0; k_start = '0; k_stop = '0; k_step = '0; dwell = '0; p_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cycle("reset", '{k: 32'd0, busy: 1'b0, done: 1'b0, tick: 1'b0}, 11'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_cycle("post_reset", '{k: 32'd0, busy: 1'b0, done: 1'b0, tick: 1'b0}, 11'd0);

    run_sweep("single",  2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 11'h155, 0);
    run_sweep("clamp",   2'd0, 32'd0,   32'd25,  32'd10, 16'd0, 11'h0AA, 0);
    run_sweep("tri",     2'd2, 32'd4,   32'd10,  32'd3,  16'd0, 11'h7FF, 14);
    run_sweep("saw_ovf", 2'd1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 16'd0, 11'h001, 10);
    run_sweep("step0",   2'd0, 32'd50,  32'd60,  32'd0,  16'd1, 11'h123, 0);
    run_sweep("inverted",2'd2, 32'd90,  32'd60,  32'd5,  16'd1, 11'h321, 0);
    run_sweep("tri_flat",2'd2, 32'd77,  32'd77,  32'd5,  16'd1, 11'h456, 9);

    // start and abort together in IDLE: nothing launches, K/P keep last sweep.
    mode = 2'd0; k_start = 32'd777; k_stop = 32'd999; k_step = 32'd1; dwell = 16'd0;
    p_offset = 11'h3C3;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_cycle("start_abort", '{k: 32'd77, busy: 1'b0, done: 1'b0, tick: 1'b0}, 11'h456);
    @(posedge clk); #1;
    check_cycle("start_abort+1", '{k: 32'd77, busy: 1'b0, done: 1'b0, tick: 1'b0}, 11'h456);

    for (int r = 0; r < 60; r++) begin
      rm  = 2'($urandom_range(0, 3));
      rst = 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 9) == 0) rst = '0;
      rks  = $urandom;
      ke64 = 64'(rks) + 64'(rst) * 64'($urandom_range(0, 5)) + 64'($urandom_range(0, 999));
      rke  = (ke64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(ke64);
      if ($urandom_range(0, 9) == 0 && rks != 0) rke = rks - 32'd1;
      rdw = 16'($urandom_range(0, 3));
      if (rm == 2'd1 || rm == 2'd2) ab = $urandom_range(1, 40);
      else ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      run_sweep($sformatf("rnd%0d", r), rm, rks, rke, rst, rdw, 11'($urandom), ab);
    end

    // Asynchronous reset in the middle of a sweep, while K=110.
    mode = 2'd0; k_start = 32'd100; k_stop = 32'd130; k_step = 32'd10; dwell = 16'd2;
    p_offset = 11'h2A5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mid.pre_K", 64'(K), 64'd110);
    #2 rst_n = 1'b0;
    #1;
    check_cycle("rst_mid", '{k: 32'd0, busy: 1'b0, done: 1'b0, tick: 1'b0}, 11'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_cycle($sformatf("rst_after[%0d]", i),
                  '{k: 32'd0, busy: 1'b0, done: 1'b0, tick: 1'b0}, 11'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
